sha1_block_engine: RTL and testbench
====================================

Name: sha1_block_engine

Overview:
Parametrised SHA-1 compression engine and successor to the single-round cycle pipeline. It accepts one 512-bit block as sixteen 32-bit words and runs all 80 rounds at UNROLL rounds per clock. It then performs the final feed-forward add into the chaining state H0..H4 and presents the 160-bit digest. It supports multi-block messages by chaining from the previous digest, so a hashing front end can stream padded blocks directly into it.

Parameters:
UNROLL, 1, rounds computed per clock; legal values 1, 2, 4, 5 (all divide 20); any other value is an elaboration error.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  in_word is valid this cycle
in_ready  out  1  engine accepts a word this cycle
in_word  in  32  message word; W0 first, big-endian within the word
in_first  in  1  sampled only with word 0: 1 = start from IV, 0 = chain from current H
out_valid  out  1  out_digest holds a completed block result
out_ready  in  1  consumer accepts the digest
out_digest  out  160  {H0,H1,H2,H3,H4}; H0 in bits 159:128
busy  out  1  high in ROUND and FINAL states

Behaviour:
- Reset (async, rst=1):
  - state=LOAD, word_cnt=0, round_cnt=0, out_valid=0.
  - H0..H4 are set to the IV: 67452301, efcdab89, 98badcfe, 10325476, c3d2e1f0.
  - in_ready=1 and busy=0 follow from the LOAD state.
  - Words presented while rst=1 are ignored.
- State machine: LOAD -> ROUND -> FINAL -> OUTPUT -> LOAD.
- LOAD:
  - in_ready=1. A word is accepted on each edge with in_valid=1 and shifts into a 16-entry W window; word_cnt increments.
  - On word 0, in_first is sampled. If 1, H and working regs A..E are loaded from the IV. If 0, A..E are loaded from the current H.
  - Bubbles (in_valid=0) stall the load without losing state.
  - When word 15 is accepted, the next state is ROUND with round_cnt=0.
- ROUND:
  - in_ready=0. Each edge applies rounds t .. t+UNROLL-1 combinationally chained, then round_cnt advances by UNROLL.
  - For t>=16: W_t = rol1(W_{t-3} ^ W_{t-8} ^ W_{t-14} ^ W_{t-16}), produced from the sliding window. The window advances UNROLL words per edge.
  - f and k are selected per round by t/20. UNROLL divides 20, so one edge never spans a phase boundary within a group. Each unrolled slot still computes its own t.
  - Ch with 5a827999 for t<20; parity with 6ed9eba1 for t<40; majority with 8f1bbcdc for t<60; parity with ca62c1d6 otherwise.
  - Round update: T = rol5(A) + f(B,C,D) + E + k + W_t; then E<=D, D<=C, C<=rol30(B), B<=A, A<=T. All adds are mod 2^32.
  - The edge completing round 79 moves to FINAL.
- FINAL: one edge performs Hi <= Hi + {A..E}i (mod 2^32) and sets out_valid=1. Next state is OUTPUT.
- Latency: with the last word accepted at edge e0, out_valid first rises at edge e0 + 80/UNROLL + 1. That is 81, 41, 21 or 17 edges for UNROLL 1, 2, 4, 5.
- OUTPUT:
  - out_valid stays 1 and out_digest is stable until an edge with out_ready=1. On that edge out_valid<=0 and the state returns to LOAD.
  - in_ready=0 throughout OUTPUT; no overlap with the next load.
- out_digest always reflects H. After the handshake it keeps the last value until the next FINAL or reset.
- Chaining on the first block after reset with in_first=0 uses the reset IV, which is legal and gives the same result as in_first=1.
- Reset mid-operation (LOAD, ROUND, FINAL or OUTPUT) aborts the block immediately:
  - out_valid drops asynchronously and H returns to the IV.
  - A partially loaded block is discarded.
- in_first on words 1..15 is ignored.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset, UNROLL=1. Load block 61626380, 14×00000000, 00000018 with in_first=1 and out_ready=1 -> out_valid at e0+81, digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, busy high for 81 cycles.
- Same "abc" block with UNROLL=2, 4 and 5 -> identical digest, out_valid at e0+41, +21 and +17 respectively.
- Two-block padded "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", first block in_first=1, second in_first=0 -> final digest 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
- "abc" with out_ready=0 for 10 cycles after out_valid -> out_valid held, digest stable, in_ready=0. Word presented in that window is not accepted. Release -> LOAD next edge.
- "abc" load with random in_valid gaps, and in_first toggled on words 1..15 -> digest still a9993e36...
- Assert rst mid-ROUND -> out_valid=0 and in_ready=1 after release. Then empty-message block 80000000 + 15 zeros with in_first=0 -> da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.

Source files
------------

// File: rtl/sha1_block_if.sv
// sha1_block_if: word-in / digest-out handshake bundle for sha1_block_engine
interface sha1_block_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_word;
    logic         in_first;
    logic         out_valid;
    logic         out_ready;
    logic [159:0] out_digest;
    logic         busy;
    modport master (
        output in_valid, in_word, in_first, out_ready,
        input  in_ready, out_valid, out_digest, busy
    );
    modport slave (
        input  in_valid, in_word, in_first, out_ready,
        output in_ready, out_valid, out_digest, busy
    );
endinterface

// File: rtl/sha1_block_engine.sv
// sha1_block_engine: SHA-1 compression of one 512-bit block at UNROLL rounds per clock,
// with feed-forward into H so consecutive blocks chain.
module sha1_block_engine #(
    parameter int UNROLL = 1
) (
    input logic         clk,
    input logic         rst,
    sha1_block_if.slave bus
);
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5)) begin : g_bad_unroll
        $error("sha1_block_engine: UNROLL must be 1, 2, 4 or 5");
    end
    typedef enum logic [1:0] {LOAD, ROUND, FINAL, OUTPUT} state_t;
    localparam logic [31:0] IV [5] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                       32'h10325476, 32'hc3d2e1f0};
    state_t      state_q, state_d;
    logic [3:0]  word_cnt_q, word_cnt_d;
    logic [6:0]  round_cnt_q, round_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic [31:0] v_q [5];
    logic [31:0] v_d [5];
    logic [31:0] h_q [5];
    logic [31:0] h_d [5];
    logic [31:0] wx [16+UNROLL];
    logic [31:0] s [UNROLL+1][5];
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction
    function automatic logic [31:0] fk(input logic [6:0] t, input logic [31:0] b, c, d);
        return t < 7'd20 ? ((b & c) | (~b & d)) + 32'h5a827999 :
               t < 7'd40 ? (b ^ c ^ d) + 32'h6ed9eba1 :
               t < 7'd60 ? ((b & c) | (b & d) | (c & d)) + 32'h8f1bbcdc :
                           (b ^ c ^ d) + 32'hca62c1d6;
    endfunction
    // wx[j] holds W_{t+j}; the entries past 15 are the schedule words this edge needs
    always_comb begin
        for (int j = 0; j < 16; j++) wx[j] = w_q[j];
        for (int j = 16; j < 16 + UNROLL; j++)
            wx[j] = rol(wx[j-3] ^ wx[j-8] ^ wx[j-14] ^ wx[j-16], 1);
        for (int i = 0; i < 5; i++) s[0][i] = v_q[i];
        for (int u = 0; u < UNROLL; u++) begin
            s[u+1][0] = rol(s[u][0], 5) + fk(round_cnt_q + 7'(u), s[u][1], s[u][2], s[u][3])
                        + s[u][4] + wx[u];
            s[u+1][1] = s[u][0];
            s[u+1][2] = rol(s[u][1], 30);
            s[u+1][3] = s[u][2];
            s[u+1][4] = s[u][3];
        end
    end
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        round_cnt_d = round_cnt_q;
        out_valid_d = out_valid_q;
        w_d         = w_q;
        v_d         = v_q;
        h_d         = h_q;
        if (state_q == LOAD && bus.in_valid) begin
            for (int j = 0; j < 15; j++) w_d[j] = w_q[j+1];
            w_d[15]    = bus.in_word;
            word_cnt_d = word_cnt_q + 4'd1;
            if (word_cnt_q == 4'd0) begin
                for (int i = 0; i < 5; i++) begin
                    h_d[i] = bus.in_first ? IV[i] : h_q[i];
                    v_d[i] = bus.in_first ? IV[i] : h_q[i];
                end
            end
            round_cnt_d = '0;
            state_d     = word_cnt_q == 4'd15 ? ROUND : LOAD;
        end
        if (state_q == ROUND) begin
            for (int j = 0; j < 16; j++) w_d[j] = wx[j+UNROLL];
            for (int i = 0; i < 5; i++) v_d[i] = s[UNROLL][i];
            round_cnt_d = round_cnt_q + 7'(UNROLL);
            state_d     = round_cnt_q == 7'(80 - UNROLL) ? FINAL : ROUND;
        end
        if (state_q == FINAL) begin
            for (int i = 0; i < 5; i++) h_d[i] = h_q[i] + v_q[i];
            out_valid_d = 1'b1;
            state_d     = OUTPUT;
        end
        if (state_q == OUTPUT && bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = LOAD;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            word_cnt_q  <= '0;
            round_cnt_q <= '0;
            out_valid_q <= 1'b0;
            w_q         <= '{default: '0};
            v_q         <= '{default: '0};
            h_q         <= IV;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            round_cnt_q <= round_cnt_d;
            out_valid_q <= out_valid_d;
            w_q         <= w_d;
            v_q         <= v_d;
            h_q         <= h_d;
        end
    end
    assign bus.in_ready   = state_q == LOAD;
    assign bus.busy       = state_q == ROUND || state_q == FINAL;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_digest = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
endmodule

// File: tb/tb_sha1_block_engine.sv
// tb_sha1_block_engine: drives four engines (UNROLL 1,2,4,5) in lockstep and checks
// digests, latency and handshakes against known vectors and a textbook SHA-1 model.
module tb_sha1_block_engine;
    localparam int US [4] = '{1, 2, 4, 5};
    localparam logic [159:0] IV160  = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
    localparam logic [159:0] ABC    = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] TWOBLK = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;
    localparam logic [159:0] EMPTY  = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_first, out_ready;
    logic [31:0] in_word;
    logic [3:0] ov, ir, bz;
    logic [3:0][159:0] dg;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha1_block_if bus ();
        assign bus.in_valid  = in_valid;
        assign bus.in_word   = in_word;
        assign bus.in_first  = in_first;
        assign bus.out_ready = out_ready;
        assign ov[g] = bus.out_valid;
        assign ir[g] = bus.in_ready;
        assign bz[g] = bus.busy;
        assign dg[g] = bus.out_digest;
        sha1_block_engine #(.UNROLL(US[g])) dut (.clk(clk), .rst(rst), .bus(bus));
    end
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction
    function automatic logic [159:0] sha1_ref(input logic [159:0] hin, input logic [31:0] m [16]);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 80; i++)
            w[i] = i < 16 ? m[i] : rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        {a, b, c, d, e} = hin;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            t = rol(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rol(b, 30); b = a; a = t;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction
    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic load_block(input logic [31:0] m [16], input logic first, input bit gaps, input bit tog);
        for (int i = 0; i < 16;) begin
            @(negedge clk);
            in_first = tog ? 1'($urandom_range(0, 1)) : first;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_word  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_word  = m[i];
                if (i == 0) in_first = first;
                i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask
    task automatic run_block(input string tag, input logic [31:0] m [16], input logic first,
                             input bit gaps, input bit tog, input logic [159:0] exp);
        int lat [4];
        int bc [4];
        logic [159:0] got [4];
        lat = '{default: 0};
        bc  = '{default: 0};
        got = '{default: '0};
        load_block(m, first, gaps, tog);
        for (int n = 0; n < 100; n++) begin
            for (int g = 0; g < 4; g++) begin
                if (bz[g]) bc[g]++;
                if (ov[g] && lat[g] == 0) begin
                    lat[g] = n;
                    got[g] = dg[g];
                end
            end
            @(negedge clk);
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s_lat_u%0d", tag, US[g]), 160'(lat[g]), 160'(80 / US[g] + 1));
            chk($sformatf("%s_busy_u%0d", tag, US[g]), 160'(bc[g]), 160'(80 / US[g] + 1));
            chk($sformatf("%s_dig_u%0d", tag, US[g]), got[g], exp);
        end
        chk({tag, "_back_to_load"}, 160'(ir), 160'(4'hf));
    endtask
    initial begin
        logic [31:0] abc [16];
        logic [31:0] b1 [16];
        logic [31:0] b2 [16];
        logic [31:0] emp [16];
        logic [31:0] rb [16];
        logic [159:0] hm;
        logic rf;
        abc = '{default: '0}; abc[0] = 32'h61626380; abc[15] = 32'h00000018;
        emp = '{default: '0}; emp[0] = 32'h80000000;
        b1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
               32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        b2 = '{default: '0}; b2[15] = 32'h000001c0;
        rst = 1'b1; in_valid = 1'b1; in_word = 32'hdeadbeef; in_first = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 160'(ov), 160'(4'h0));
        chk("rst_in_ready", 160'(ir), 160'(4'hf));
        chk("rst_busy", 160'(bz), 160'(4'h0));
        for (int g = 0; g < 4; g++) chk($sformatf("rst_iv_u%0d", US[g]), dg[g], IV160);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        run_block("abc", abc, 1'b1, 1'b0, 1'b0, ABC);
        hm = sha1_ref(IV160, b1);
        run_block("two_b1", b1, 1'b1, 1'b0, 1'b0, hm);
        run_block("two_b2", b2, 1'b0, 1'b0, 1'b0, TWOBLK);
        out_ready = 1'b0;
        load_block(abc, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 120 && ov != 4'hf; n++) @(negedge clk);
        chk("hold_all_valid", 160'(ov), 160'(4'hf));
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_word  = $urandom;
            @(negedge clk);
            chk("hold_valid", 160'(ov), 160'(4'hf));
            chk("hold_in_ready", 160'(ir), 160'(4'h0));
            for (int g = 0; g < 4; g++) chk($sformatf("hold_dig_u%0d", US[g]), dg[g], ABC);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 160'(ov), 160'(4'h0));
        chk("release_load", 160'(ir), 160'(4'hf));
        for (int g = 0; g < 4; g++) chk($sformatf("release_keep_u%0d", US[g]), dg[g], ABC);
        run_block("abc_gaps", abc, 1'b1, 1'b1, 1'b1, ABC);
        hm = IV160;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) rb[i] = $urandom;
            rf = r == 0 ? 1'b1 : 1'($urandom_range(0, 1));
            hm = sha1_ref(rf ? IV160 : hm, rb);
            run_block($sformatf("rand%0d", r), rb, rf, 1'b1, 1'b0, hm);
        end
        out_ready = 1'b0;
        load_block(abc, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 120 && ov != 4'hf; n++) @(negedge clk);
        chk("pre_async_valid", 160'(ov), 160'(4'hf));
        #2 rst = 1'b1;
        #1 chk("async_drop_valid", 160'(ov), 160'(4'h0));
        for (int g = 0; g < 4; g++) chk($sformatf("async_iv_u%0d", US[g]), dg[g], IV160);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        load_block(abc, 1'b1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("mid_round_busy", 160'(bz), 160'(4'hf));
        rst = 1'b1;
        #1 chk("mid_round_rst_valid", 160'(ov), 160'(4'h0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_in_ready", 160'(ir), 160'(4'hf));
        chk("after_rst_valid", 160'(ov), 160'(4'h0));
        for (int g = 0; g < 4; g++) chk($sformatf("after_rst_iv_u%0d", US[g]), dg[g], IV160);
        run_block("empty_chain", emp, 1'b0, 1'b0, 1'b0, EMPTY);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
